mod_reducer: RTL and testbench
==============================

# mod_reducer

Sequential binary-to-residue converter. It reduces a W-bit binary operand to its residue modulo m, in the range 0..m-1. It is the front end of the modular adder/subtractor and produces operands already inside [0, m-1], which that combinational block requires. Reduction is MSB-first (Horner), one operand bit per clock, with valid/ready handshakes on both sides.

## Interface

Parameters:
- `m`, default 4'b1111: modulus. Legal range 4'b0010..4'b1111; the adder family uses 4'b1001..4'b1111. Must be set to the same value as the downstream adder's `m`.
- `W`, default 16: operand width in bits, W ≥ 2.

Ports (one clock; reset is asynchronous and active-low):
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: asynchronous active-low reset.
- `a`, input, W: operand. Sampled only on an accepted start.
- `in_valid`, input, 1: operand request.
- `in_ready`, output, 1: high only in IDLE.
- `r3`, `r2`, `r1`, `r0`, outputs, 1 each: residue bits, MSB first. They wire directly to the adder's x or y inputs.
- `out_valid`, output, 1: residue is valid and held.
- `out_ready`, input, 1: consumer accepts the residue.

## Operation

- States: IDLE, RUN, (FIX, only when `MODRED_SIGNED_EN` is defined), HOLD.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`=1, at the clock edge: latch `a` into a W-bit shift register, clear the accumulator to 0, load the bit counter with W-1, and go to RUN.
- RUN, each cycle:
  - Compute t = 2·acc + shreg[W-1] in 5 bits. The maximum is 2m-1.
  - acc ← (t ≥ m) ? t-m : t. A single conditional subtract is sufficient; no loop is needed.
  - Shift shreg left by one and decrement the counter.
  - When the counter is 0 after this step, go to HOLD, or to FIX if the macro is defined.
- HOLD:
  - `out_valid`=1 and r3..r0 = acc, held stable.
  - On `out_ready`=1, go to IDLE.
- `in_valid` outside IDLE is ignored; there is no queuing. An `in_valid` in the same cycle as the HOLD→IDLE transition is not accepted, because `in_ready` was 0 in that cycle.
- The accumulator never holds a value ≥ m.
- r3..r0 are driven only from acc. They may change during RUN but are meaningful only while `out_valid`=1.

## Timing

- Reset (async assert, sync release by the clock domain):
  - State=IDLE.
  - acc=0, so r3..r0=0.
  - `out_valid`=0, `in_ready`=1.
  - shreg=0, counter=0.
- Reset asserted mid-operation: the operation is abandoned immediately. Outputs go to reset values and no residue is produced.
- Latency:
  - The accept edge is edge 0. `out_valid` rises after edge W (unsigned build) or edge W+1 (signed build).
  - The latency is fixed and independent of the data.
- Throughput: one operand per W+2 cycles (W+3 signed) with `out_ready` tied high. That is the accept edge, W iteration edges, the FIX edge in the signed build, and one HOLD cycle.
- Back-pressure: HOLD persists indefinitely while `out_ready`=0, with r3..r0 and `out_valid` constant.
- `in_ready` and `out_valid` are decoded from registered state only, with no combinational path from inputs.

## Configuration

Macro: `MODRED_SIGNED_EN`.

- Defined:
  - `a` is two's complement.
  - On accept, load the magnitude |a| into shreg. |−2^(W−1)| = 2^(W−1) fits in W unsigned bits.
  - Register the sign.
  - After RUN, enter FIX for one cycle: if the sign is set and acc≠0, then acc ← m−acc. Otherwise acc is unchanged.
  - FIX is always visited, so latency is constant.
- Undefined:
  - `a` is unsigned.
  - There is no FIX state and no sign register.

## Test plan

- W=16, m=15, unsigned build, a=16'd1000, `out_ready`=1: `out_valid` rises after edge 16, r3..r0=4'b1010 (10). `in_ready` returns high one cycle after `out_valid`.
- W=16, m=15, unsigned build, a=16'hFFFF: r=0. Confirms that the output is never equal to m.
- W=16, m=9, unsigned build, a=16'd100: r=4'b0001. Hold `out_ready`=0 for 5 cycles and confirm r3..r0 and `out_valid` stay constant and that `in_valid` pulses are ignored. Raise `out_ready` and confirm IDLE on the next edge.
- Reset mid-operation: assert `rst_n`=0 at RUN cycle 7. Outputs must be zero immediately, with `in_ready`=1. A fresh a=16'd37 with m=15 then yields 7.
- Signed build, W=16, m=15: a=−1 gives 14; a=16'h8000 (−32768) gives 7; a=−15 gives 0. `out_valid` rises after edge 17.
- Exhaustive check: for each m in 9..15 and each a in 0..2^W−1 (W=8), the residue equals a mod m. Feeding two residues into the adder must reproduce the adder's own self-check results.

Source files
------------

// File: rtl/mod_reducer.sv
// Sequential binary-to-residue converter: MSB-first Horner reduction of a W-bit operand modulo m.
// Define MODRED_SIGNED_EN to treat the operand as two's complement (adds a one-cycle FIX state).
module mod_reducer #(
   parameter logic [3:0] m = 4'b1111,
   parameter int         W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] a,
   input  logic         in_valid,
   output logic         in_ready,
   output logic         r3,
   output logic         r2,
   output logic         r1,
   output logic         r0,
   output logic         out_valid,
   input  logic         out_ready
);

   localparam int CW = (W > 2) ? $clog2(W) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(W - 1);

`ifdef MODRED_SIGNED_EN
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIX = 2'd2, S_HOLD = 2'd3} state_t;
`else
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_HOLD = 2'd3} state_t;
`endif

   state_t        state_q;
   logic [W-1:0]  shreg_q;
   logic [CW-1:0] cnt_q;
   logic [3:0]    acc_q;
   logic          in_ready_q;
   logic          out_valid_q;
   logic [4:0]    t_d;
   logic [3:0]    step_d;
   logic [W-1:0]  load_d;

   // acc < m keeps t below 2m, so one conditional subtract lands back in [0, m-1]
   assign t_d    = {acc_q, shreg_q[W-1]};
   assign step_d = (t_d >= {1'b0, m}) ? 4'(t_d - {1'b0, m}) : t_d[3:0];

`ifdef MODRED_SIGNED_EN
   logic          sign_q;
   logic [3:0]    fix_d;
   // Magnitude of the most negative value is 2^(W-1), which still fits unsigned in W bits
   assign load_d = a[W-1] ? (~a + {{(W-1){1'b0}}, 1'b1}) : a;
   assign fix_d  = (sign_q && (acc_q != 4'd0)) ? (m - acc_q) : acc_q;
`else
   assign load_d = a;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         shreg_q     <= '0;
         cnt_q       <= '0;
         acc_q       <= 4'd0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
`ifdef MODRED_SIGNED_EN
         sign_q      <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  shreg_q    <= load_d;
                  acc_q      <= 4'd0;
                  cnt_q      <= CNT_LOAD;
                  in_ready_q <= 1'b0;
                  state_q    <= S_RUN;
`ifdef MODRED_SIGNED_EN
                  sign_q     <= a[W-1];
`endif
               end
            end
            S_RUN: begin
               acc_q   <= step_d;
               shreg_q <= {shreg_q[W-2:0], 1'b0};
               if (cnt_q == '0) begin
`ifdef MODRED_SIGNED_EN
                  state_q     <= S_FIX;
`else
                  state_q     <= S_HOLD;
                  out_valid_q <= 1'b1;
`endif
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
`ifdef MODRED_SIGNED_EN
            S_FIX: begin
               acc_q       <= fix_d;
               state_q     <= S_HOLD;
               out_valid_q <= 1'b1;
            end
`endif
            S_HOLD: begin
               if (out_ready) begin
                  state_q     <= S_IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign r3        = acc_q[3];
   assign r2        = acc_q[2];
   assign r1        = acc_q[1];
   assign r0        = acc_q[0];

endmodule

// File: tb/tb_mod_reducer.sv
// Self-checking bench for mod_reducer: directed vector table, reset-abort sequence and random
// operands checked against an arithmetic residue model; honours MODRED_SIGNED_EN.
module tb_mod_reducer;

   localparam int W = 16;
`ifdef MODRED_SIGNED_EN
   localparam int LAT = W + 1;
`else
   localparam int LAT = W;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [W-1:0] a_s = '0;
   logic         iv15 = 1'b0, iv9 = 1'b0, ordy15 = 1'b0, ordy9 = 1'b0;
   logic         ir15, ir9, ov15, ov9;
   logic         r3_15, r2_15, r1_15, r0_15, r3_9, r2_9, r1_9, r0_9;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mod_reducer #(.m(4'd15), .W(W)) u15 (
      .clk(clk), .rst_n(rst_n), .a(a_s), .in_valid(iv15), .in_ready(ir15),
      .r3(r3_15), .r2(r2_15), .r1(r1_15), .r0(r0_15),
      .out_valid(ov15), .out_ready(ordy15));

   mod_reducer #(.m(4'd9), .W(W)) u9 (
      .clk(clk), .rst_n(rst_n), .a(a_s), .in_valid(iv9), .in_ready(ir9),
      .r3(r3_9), .r2(r2_9), .r1(r1_9), .r0(r0_9),
      .out_valid(ov9), .out_ready(ordy9));

   function automatic logic [3:0] cur_r(input int which);
      return which ? {r3_9, r2_9, r1_9, r0_9} : {r3_15, r2_15, r1_15, r0_15};
   endfunction
   function automatic logic cur_ov(input int which);
      return which ? ov9 : ov15;
   endfunction
   function automatic logic cur_ir(input int which);
      return which ? ir9 : ir15;
   endfunction

   // Reference: the residue of the operand's numeric value, always in 0..m-1
   function automatic int ref_mod(input logic [W-1:0] av, input int mm);
      int v;
      int r;
`ifdef MODRED_SIGNED_EN
      v = int'($signed(av));
`else
      v = int'({16'd0, av});
`endif
      r = v % mm;
      if (r < 0) r += mm;
      return r;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic set_iv(input int which, input logic v);
      if (which != 0) iv9 = v; else iv15 = v;
   endtask
   task automatic set_or(input int which, input logic v);
      if (which != 0) ordy9 = v; else ordy15 = v;
   endtask

   task automatic do_op(input int which, input logic [W-1:0] av, input int exp,
                        input int hold, input string name);
      int lat;
      logic [3:0] held;
      @(negedge clk);
      a_s = av;
      set_iv(which, 1'b1);
      chk({name, " in_ready_idle"}, int'(cur_ir(which)), 1);
      @(posedge clk); #1;
      set_iv(which, 1'b0);
      a_s = ~av;
      chk({name, " in_ready_busy"}, int'(cur_ir(which)), 0);
      lat = 0;
      while (!cur_ov(which) && lat < LAT + 4) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({name, " latency"}, lat, LAT);
      chk({name, " residue"}, int'(cur_r(which)), exp);
      held = cur_r(which);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         set_iv(which, 1'b1);
         @(posedge clk); #1;
         set_iv(which, 1'b0);
         chk({name, " hold_valid"}, int'(cur_ov(which)), 1);
         chk({name, " hold_residue"}, int'(cur_r(which)), int'(held));
      end
      @(negedge clk);
      set_or(which, 1'b1);
      set_iv(which, 1'b1);
      @(posedge clk); #1;
      set_or(which, 1'b0);
      set_iv(which, 1'b0);
      chk({name, " back_to_idle"}, int'({cur_ir(which), cur_ov(which)}), 2);
      $display("op %s: unit m=%0d a=%h residue=%0d latency=%0d", name, which ? 9 : 15, av, held, lat);
   endtask

   typedef struct {
      logic [W-1:0] a;
      int           which;
      int           exp;
      int           hold;
      string        name;
   } vec_t;

   vec_t vecs[$];

   initial begin
`ifdef MODRED_SIGNED_EN
      vecs.push_back('{16'd1000, 0, 10, 0, "pos1000_m15"});
      vecs.push_back('{16'hFFFF, 0, 14, 0, "neg1_m15"});
      vecs.push_back('{16'h8000, 0, 7,  0, "min_m15"});
      vecs.push_back('{16'hFFF1, 0, 0,  0, "neg15_m15"});
      vecs.push_back('{16'd100,  1, 1,  5, "100_m9_backpressure"});
      vecs.push_back('{16'hFFFF, 1, 8,  0, "neg1_m9"});
`else
      vecs.push_back('{16'd1000, 0, 10, 0, "1000_m15"});
      vecs.push_back('{16'hFFFF, 0, 0,  0, "ffff_m15"});
      vecs.push_back('{16'd100,  1, 1,  5, "100_m9_backpressure"});
      vecs.push_back('{16'hFFFF, 1, 6,  0, "ffff_m9"});
      vecs.push_back('{16'd0,    0, 0,  0, "zero_m15"});
      vecs.push_back('{16'd14,   0, 14, 1, "14_m15"});
`endif

      #12;
      chk("reset in_ready", int'({ir15, ir9}), 3);
      chk("reset out_valid", int'({ov15, ov9}), 0);
      chk("reset residue", int'({cur_r(0), cur_r(1)}), 0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) do_op(vecs[i].which, vecs[i].a, vecs[i].exp, vecs[i].hold, vecs[i].name);

      // Abandon an operation part-way through RUN with an asynchronous reset
      @(negedge clk);
      a_s = 16'hBEEF;
      iv15 = 1'b1;
      @(posedge clk); #1;
      iv15 = 1'b0;
      repeat (7) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midreset in_ready", int'(ir15), 1);
      chk("midreset out_valid", int'(ov15), 0);
      chk("midreset residue", int'(cur_r(0)), 0);
      @(negedge clk);
      rst_n = 1'b1;
      $display("op midreset: operation abandoned, outputs cleared");
      do_op(0, 16'd37, 7, 0, "37_after_reset");

      for (int n = 0; n < 40; n++) begin
         logic [W-1:0] rv;
         int           wsel;
         rv   = W'($urandom);
         if (n < 4) rv = (n % 2 == 0) ? 16'h8000 : 16'h7FFF;
         wsel = n % 2;
         do_op(wsel, rv, ref_mod(rv, wsel ? 9 : 15), int'($urandom_range(0, 2)), "random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
